// File: rtl/flag_cdc_pkg.sv
// +----------------------------------------------------------------------+
// | flag_cdc_pkg: shared types/limits for the toggle-flag CDC handshake   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package flag_cdc_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } rxState_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_DEFAULT   = 16;

  // Keeps an out-of-range synchroniser depth inside the supported window.
  function automatic int clampStages(input int stages);
    if (stages < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (stages > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return stages;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bit_chain.sv
// +----------------------------------------------------------------------+
// | sync_bit_chain: single-bit multi-flop synchroniser, sync reset to 0   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sync_bit_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/flag_ack_receiver.sv
// +----------------------------------------------------------------------+
// | flag_ack_receiver: destination end of toggle-flag/ack CDC handshake   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module flag_ack_receiver
  import flag_cdc_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter bit ACK_ON_ACCEPT = 1'b1,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic             clkB,
  input  logic             rstB,
  input  logic             ToggleIn_async,
  input  logic             Ready_clkB,
  output logic             Valid_clkB,
  output logic             AckToggle_clkB,
  output logic [CNT_W-1:0] EventCount_clkB,
  output logic             Overrun_clkB,
  input  logic             ClearOverrun_clkB
);

  localparam int c_stages = clampStages(SYNC_STAGES);

  logic             w_syncOut;
  logic             r_hist;
  logic             w_edge;
  rxState_t         r_state;
  rxState_t         w_stateNext;
  logic             w_ackFlip;
  logic             w_accept;
  logic             w_overrunSet;
  logic             r_ack;
  logic [CNT_W-1:0] r_eventCount;
  logic             r_overrun;

  sync_bit_chain #(
    .STAGES (c_stages)
  ) u_sync (
    .clk  (clkB),
    .rstN (rstB),
    .d    (ToggleIn_async),
    .q    (w_syncOut)
  );

  assign w_edge = w_syncOut ^ r_hist;

  always_comb begin
    w_stateNext  = r_state;
    w_ackFlip    = 1'b0;
    w_accept     = 1'b0;
    w_overrunSet = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_stateNext = PENDING;
          w_ackFlip   = !ACK_ON_ACCEPT;
        end
      end
      PENDING: begin
        if (Ready_clkB) begin
          // A new edge coinciding with accept is taken as the next pending event.
          w_accept    = 1'b1;
          w_ackFlip   = ACK_ON_ACCEPT ? 1'b1 : w_edge;
          w_stateNext = w_edge ? PENDING : IDLE;
        end else if (w_edge) begin
          w_overrunSet = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkB) begin
    if (!rstB) begin
      r_state      <= IDLE;
      r_hist       <= 1'b0;
      r_ack        <= 1'b0;
      r_eventCount <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_hist  <= w_syncOut;
      if (w_ackFlip) begin
        r_ack <= ~r_ack;
      end
      if (w_accept) begin
        r_eventCount <= r_eventCount + CNT_W'(1);
      end
      if (w_overrunSet) begin
        r_overrun <= 1'b1;
      end else if (ClearOverrun_clkB) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign Valid_clkB      = (r_state == PENDING);
  assign AckToggle_clkB  = r_ack;
  assign EventCount_clkB = r_eventCount;
  assign Overrun_clkB    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_flag_ack_receiver.sv
// +----------------------------------------------------------------------+
// | tb_flag_ack_receiver: directed vectors for flag_ack_receiver          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_flag_ack_receiver;

  logic clkB = 1'b0;
  always #5 clkB = ~clkB;

  logic rstB;

  // A: ack on accept, 16-bit count
  logic togA, rdyA, clrA, validA, ackA, ovrA;
  logic [15:0] cntA;
  // B: fire-and-forget ack
  logic togB, rdyB, clrB, validB, ackB, ovrB;
  logic [15:0] cntB;
  // C: ack on accept, 4-bit count for wrap
  logic togC, rdyC, clrC, validC, ackC, ovrC;
  logic [3:0] cntC;

  flag_ack_receiver #(.SYNC_STAGES(2), .ACK_ON_ACCEPT(1'b1), .CNT_W(16)) dutA (
    .clkB(clkB), .rstB(rstB), .ToggleIn_async(togA), .Ready_clkB(rdyA),
    .Valid_clkB(validA), .AckToggle_clkB(ackA), .EventCount_clkB(cntA),
    .Overrun_clkB(ovrA), .ClearOverrun_clkB(clrA));

  flag_ack_receiver #(.SYNC_STAGES(2), .ACK_ON_ACCEPT(1'b0), .CNT_W(16)) dutB (
    .clkB(clkB), .rstB(rstB), .ToggleIn_async(togB), .Ready_clkB(rdyB),
    .Valid_clkB(validB), .AckToggle_clkB(ackB), .EventCount_clkB(cntB),
    .Overrun_clkB(ovrB), .ClearOverrun_clkB(clrB));

  flag_ack_receiver #(.SYNC_STAGES(2), .ACK_ON_ACCEPT(1'b1), .CNT_W(4)) dutC (
    .clkB(clkB), .rstB(rstB), .ToggleIn_async(togC), .Ready_clkB(rdyC),
    .Valid_clkB(validC), .AckToggle_clkB(ackC), .EventCount_clkB(cntC),
    .Overrun_clkB(ovrC), .ClearOverrun_clkB(clrC));

  typedef struct {
    logic        tog;
    logic        rdy;
    logic        clr;
    logic        expValid;
    logic        expAck;
    logic [15:0] expCnt;
    logic        expOvr;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkB);
    #1;
  endtask

  task automatic addVec(input logic t, input logic r, input logic c, input logic ev,
                        input logic ea, input logic [15:0] ec, input logic eo);
    vec_t v;
    v.tog = t; v.rdy = r; v.clr = c;
    v.expValid = ev; v.expAck = ea; v.expCnt = ec; v.expOvr = eo;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rstB = 1'b0;
    togA = 0; rdyA = 0; clrA = 0;
    togB = 0; rdyB = 0; clrB = 0;
    togC = 0; rdyC = 0; clrC = 0;

    // Event through with Ready pre-asserted, then a held event, then edge+accept overlap.
    for (int i = 0; i < 5; i++) addVec(1, 1, 0, (i == 2), (i >= 3), (i >= 3) ? 16'd1 : 16'd0, 0);
    addVec(0, 0, 0, 0, 1, 16'd1, 0);
    addVec(0, 0, 0, 0, 1, 16'd1, 0);
    for (int i = 0; i < 11; i++) addVec(0, 0, 0, 1, 1, 16'd1, 0);
    addVec(0, 1, 0, 0, 0, 16'd2, 0);
    addVec(0, 0, 0, 0, 0, 16'd2, 0);
    addVec(1, 0, 0, 0, 0, 16'd2, 0);
    addVec(1, 0, 0, 0, 0, 16'd2, 0);
    addVec(1, 0, 0, 1, 0, 16'd2, 0);
    addVec(0, 0, 0, 1, 0, 16'd2, 0);
    addVec(0, 0, 0, 1, 0, 16'd2, 0);
    addVec(0, 1, 0, 1, 1, 16'd3, 0);
    addVec(0, 1, 0, 0, 0, 16'd4, 0);
    addVec(0, 0, 1, 0, 0, 16'd4, 0);

    tick();
    tick();
    check("resetA.Valid", validA, 0);
    check("resetA.Ack", ackA, 0);
    check("resetA.Count", cntA, 0);
    check("resetA.Overrun", ovrA, 0);
    check("resetB.Ack", ackB, 0);
    check("resetC.Count", cntC, 0);
    rstB = 1'b1;

    foreach (vecs[i]) begin
      togA = vecs[i].tog;
      rdyA = vecs[i].rdy;
      clrA = vecs[i].clr;
      tick();
      check($sformatf("vecA[%0d].Valid", i), validA, vecs[i].expValid);
      check($sformatf("vecA[%0d].Ack", i), ackA, vecs[i].expAck);
      check($sformatf("vecA[%0d].Count", i), cntA, vecs[i].expCnt);
      check($sformatf("vecA[%0d].Overrun", i), ovrA, vecs[i].expOvr);
    end
    clrA = 0;

    // Reset while pending with ack=1 and count=5.
    togA = 1; rdyA = 1;
    repeat (4) tick();
    check("preRst.Count", cntA, 5);
    togA = 0; rdyA = 0;
    repeat (3) tick();
    check("preRst.Valid", validA, 1);
    check("preRst.Ack", ackA, 1);
    rstB = 1'b0;
    tick();
    check("midRst.Valid", validA, 0);
    check("midRst.Ack", ackA, 0);
    check("midRst.Count", cntA, 0);
    check("midRst.Overrun", ovrA, 0);
    rstB = 1'b1;
    repeat (5) tick();
    check("postRst.Valid", validA, 0);
    check("postRst.Count", cntA, 0);

    // Fire-and-forget: overrun, clear, set-over-clear priority, overlap flip.
    togB = 1;
    repeat (3) tick();
    check("ffB.Valid", validB, 1);
    check("ffB.Ack", ackB, 1);
    check("ffB.Overrun0", ovrB, 0);
    repeat (3) tick();
    togB = 0;
    repeat (2) tick();
    check("ffB.OverrunEarly", ovrB, 0);
    tick();
    check("ffB.OverrunSet", ovrB, 1);
    check("ffB.AckHeld", ackB, 1);
    check("ffB.ValidHeld", validB, 1);
    clrB = 1; togB = 1;
    tick();
    check("ffB.Cleared", ovrB, 0);
    repeat (2) tick();
    check("ffB.SetBeatsClear", ovrB, 1);
    clrB = 0; rdyB = 1;
    tick();
    check("ffB.AcceptValid", validB, 0);
    check("ffB.AcceptCount", cntB, 1);
    check("ffB.AcceptAck", ackB, 1);
    rdyB = 0; clrB = 1;
    tick();
    check("ffB.ClearAfter", ovrB, 0);
    clrB = 0; togB = 0;
    repeat (3) tick();
    check("ffB.Valid2", validB, 1);
    check("ffB.Ack2", ackB, 0);
    togB = 1;
    repeat (2) tick();
    rdyB = 1;
    tick();
    check("ffB.OverlapValid", validB, 1);
    check("ffB.OverlapAck", ackB, 1);
    check("ffB.OverlapCount", cntB, 2);
    check("ffB.OverlapOverrun", ovrB, 0);
    tick();
    check("ffB.FinalValid", validB, 0);
    check("ffB.FinalCount", cntB, 3);
    check("ffB.FinalAck", ackB, 1);
    rdyB = 0;

    // Count wrap with ack-paced toggles at random phase.
    rdyC = 1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clkB);
      #($urandom_range(1, 9));
      togC = ~togC;
      lat = 0;
      for (int j = 0; j < 10; j++) begin
        tick();
        lat++;
        if (validC) break;
      end
      check($sformatf("wrapC[%0d].LatencyOk", k), {31'd0, (lat >= 3 && lat <= 4)}, 1);
      for (int j = 0; j < 10; j++) begin
        if (ackC === togC) break;
        tick();
      end
      check($sformatf("wrapC[%0d].Ack", k), ackC, togC);
      if (k == 15) check("wrapC.AtZero", cntC, 0);
    end
    check("wrapC.Final", cntC, 1);
    check("wrapC.Overrun", ovrC, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
